// File: rtl/galois_lfsr_checker_if.sv
// Received word stream feeding galois_lfsr_checker: one data_in word per data_valid cycle.
interface galois_lfsr_checker_if #(
    parameter int unsigned DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;

    modport master (output data_in, output data_valid);
    modport slave  (input  data_in, input  data_valid);
endinterface

// File: rtl/galois_lfsr_checker.sv
// Regenerates the galois_lfsr nibble stream and checks received words: lock/loss FSM, error counts.
// Optional GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN adds a saturating bit-error accumulator (bit_err_count).
module galois_lfsr_checker #(
    parameter int unsigned           LFSR_WIDTH                 = 8,
    parameter int unsigned           LFSR_SEED                  = 1,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL            = LFSR_WIDTH'(8'hB8),
    parameter int unsigned           LFSR_OUTPUT_BITS_PER_CLOCK = 4,
    parameter int unsigned           LOCK_COUNT                 = 4,
    parameter int unsigned           LOSS_COUNT                 = 3,
    parameter int unsigned           ERR_CNT_WIDTH              = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  restart,
    galois_lfsr_checker_if.slave                  rx,
    output logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] expected,
    output logic                                  match_pulse,
    output logic                                  mismatch_pulse,
    output logic                                  locked,
    output logic                                  lost,
`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
    output logic [ERR_CNT_WIDTH-1:0]              err_count,
    output logic [ERR_CNT_WIDTH-1:0]              bit_err_count
`else
    output logic [ERR_CNT_WIDTH-1:0]              err_count
`endif
);

    localparam int unsigned BW     = LFSR_OUTPUT_BITS_PER_CLOCK;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT) + 1;
    localparam int unsigned BAD_W  = $clog2(LOSS_COUNT) + 1;
    localparam logic [LFSR_WIDTH-1:0]    SEED    = LFSR_WIDTH'(LFSR_SEED);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

    generate
        if (LFSR_SEED == 0 || (64'(LFSR_SEED) >> LFSR_WIDTH) != 64'd0) begin : g_seed_check
            $error("galois_lfsr_checker: LFSR_SEED must be non-zero and fit in LFSR_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_LOST   = 2'd2
    } state_t;

    state_t                  state;
    logic [LFSR_WIDTH-1:0]   ref_state;
    logic [LFSR_WIDTH-1:0]   ref_next;
    logic [BW-1:0]           exp_word;
    logic [BW-1:0]           diff;
    logic                    is_match;
    logic                    take;
    logic [GOOD_W-1:0]       good_run;
    logic [GOOD_W-1:0]       good_inc;
    logic [BAD_W-1:0]        bad_run;
    logic [BAD_W-1:0]        bad_inc;
    logic [ERR_CNT_WIDTH-1:0] err_inc;

    // One word worth of Galois steps; bit k is the k-th step's output bit.
    always_comb begin
        ref_next = ref_state;
        exp_word = '0;
        for (int k = 0; k < int'(BW); k++) begin
            exp_word[k] = ref_next[0];
            ref_next    = (ref_next >> 1) ^ (ref_next[0] ? LFSR_POLYNOMIAL : '0);
        end
    end

    always_comb begin
        diff     = rx.data_in ^ exp_word;
        is_match = (diff == '0);
        take     = rx.data_valid && (state != ST_LOST);
        good_inc = (good_run >= GOOD_W'(LOCK_COUNT)) ? good_run : good_run + GOOD_W'(1);
        bad_inc  = (bad_run  >= BAD_W'(LOSS_COUNT))  ? bad_run  : bad_run  + BAD_W'(1);
        err_inc  = (err_count == ERR_MAX) ? err_count : err_count + ERR_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_HUNT;
            ref_state      <= SEED;
            good_run       <= '0;
            bad_run        <= '0;
            expected       <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            locked         <= 1'b0;
            lost           <= 1'b0;
            err_count      <= '0;
        end else if (restart) begin
            // Restart beats a coincident data_valid: the word is dropped.
            state          <= ST_HUNT;
            ref_state      <= SEED;
            good_run       <= '0;
            bad_run        <= '0;
            expected       <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            locked         <= 1'b0;
            lost           <= 1'b0;
            err_count      <= '0;
        end else begin
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            if (take) begin
                ref_state <= ref_next;
                expected  <= exp_word;
                if (is_match) begin
                    match_pulse <= 1'b1;
                    bad_run     <= '0;
                    if (state == ST_HUNT) begin
                        good_run <= good_inc;
                        if (good_inc >= GOOD_W'(LOCK_COUNT)) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end else begin
                    mismatch_pulse <= 1'b1;
                    good_run       <= '0;
                    bad_run        <= bad_inc;
                    err_count      <= err_inc;
                    if (bad_inc >= BAD_W'(LOSS_COUNT)) begin
                        state  <= ST_LOST;
                        locked <= 1'b0;
                        lost   <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
    localparam int unsigned POP_W = $clog2(BW + 1);
    localparam int unsigned SUM_W = ((ERR_CNT_WIDTH > POP_W) ? ERR_CNT_WIDTH : POP_W) + 1;

    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] bit_sum;
    logic [ERR_CNT_WIDTH-1:0] bit_next;

    // Saturating accumulation of differing bits per checked word.
    always_comb begin
        pop = '0;
        for (int k = 0; k < int'(BW); k++) begin
            pop = pop + POP_W'(diff[k]);
        end
        bit_sum  = SUM_W'(bit_err_count) + SUM_W'(pop);
        bit_next = (bit_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : bit_sum[ERR_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_err_count <= '0;
        end else if (restart) begin
            bit_err_count <= '0;
        end else if (take) begin
            bit_err_count <= bit_next;
        end
    end
`endif

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Randomized self-checking bench for galois_lfsr_checker against a behavioural stream model.
module tb_galois_lfsr_checker;

    localparam int unsigned LOCK_N  = 4;
    localparam int unsigned LOSS_N  = 3;
    localparam int unsigned ERR_MAX = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;

    galois_lfsr_checker_if #(.DATA_WIDTH(4)) bus ();
    galois_lfsr_checker_if #(.DATA_WIDTH(4)) bus_s ();

    logic [3:0]  expected;
    logic        match_pulse, mismatch_pulse, locked, lost;
    logic [15:0] err_count;
    logic [3:0]  s_expected;
    logic        s_match, s_mismatch, s_locked, s_lost;
    logic [1:0]  s_err;
`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
    logic [15:0] bit_err_count;
    logic [1:0]  s_bit_err;
`endif

    int total = 0;
    int bad = 0;

    galois_lfsr_checker dut (
        .clk(clk), .reset(reset), .restart(restart), .rx(bus.slave),
        .expected(expected), .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
        .locked(locked), .lost(lost),
`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
        .err_count(err_count), .bit_err_count(bit_err_count)
`else
        .err_count(err_count)
`endif
    );

    galois_lfsr_checker #(.ERR_CNT_WIDTH(2), .LOSS_COUNT(8)) dut_sat (
        .clk(clk), .reset(reset), .restart(restart), .rx(bus_s.slave),
        .expected(s_expected), .match_pulse(s_match), .mismatch_pulse(s_mismatch),
        .locked(s_locked), .lost(s_lost),
`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
        .err_count(s_err), .bit_err_count(s_bit_err)
`else
        .err_count(s_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: the sequence is the polynomial-division bit stream, one word per accepted valid.
    int unsigned m_lfsr;
    int          m_expected, m_good, m_bad, m_err, m_bit_err;
    bit          m_match, m_mismatch, m_locked, m_lost;

    function automatic int gen_word(input int unsigned s_in, output int unsigned s_out);
        int w = 0;
        int unsigned s = s_in;
        for (int k = 0; k < 4; k++) begin
            if (s % 2 == 1) begin
                w = w + (1 << k);
                s = (s / 2) ^ 32'hB8;
            end else begin
                s = s / 2;
            end
        end
        s_out = s;
        return w;
    endfunction

    function automatic int model_peek();
        int unsigned dummy;
        return gen_word(m_lfsr, dummy);
    endfunction

    function automatic void model_reset();
        m_lfsr = 1; m_expected = 0; m_good = 0; m_bad = 0; m_err = 0; m_bit_err = 0;
        m_match = 0; m_mismatch = 0; m_locked = 0; m_lost = 0;
    endfunction

    function automatic void model_accept(input int w);
        int unsigned nxt;
        int ew;
        m_match = 0; m_mismatch = 0;
        if (m_lost) return;
        ew = gen_word(m_lfsr, nxt);
        m_lfsr = nxt;
        m_expected = ew;
        if (w == ew) begin
            m_match = 1; m_good++; m_bad = 0;
            if (!m_locked && m_good >= LOCK_N) m_locked = 1;
        end else begin
            m_mismatch = 1; m_good = 0; m_bad++;
            m_err = (m_err + 1 > ERR_MAX) ? ERR_MAX : m_err + 1;
            m_bit_err = m_bit_err + $countones(4'(w ^ ew));
            if (m_bit_err > ERR_MAX) m_bit_err = ERR_MAX;
            if (m_bad >= LOSS_N) begin m_lost = 1; m_locked = 0; end
        end
    endfunction

    task automatic send(input int w);
        @(negedge clk);
        bus.data_in = 4'(w); bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        model_accept(w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        m_match = 0; m_mismatch = 0;
    endtask

    task automatic do_restart();
        @(negedge clk); restart = 1'b1;
        @(posedge clk); #1; restart = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.data_valid = 1'b0; bus.data_in = '0; bus_s.data_valid = 1'b0; bus_s.data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        if ({expected, match_pulse, mismatch_pulse, locked, lost} !== 8'h00) begin
            $display("FAIL reset_flags got=%h want=00", {expected, match_pulse, mismatch_pulse, locked, lost}); bad++;
        end
        total++;
        if (err_count !== 16'd0) begin $display("FAIL reset_err got=%0d want=0", err_count); bad++; end
        total++;
    endtask

    task automatic test_lock();
        int tbl[4] = '{1, 7, 4, 10};
        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            if (expected !== 4'(tbl[i]) || 4'(m_expected) !== 4'(tbl[i])) begin
                $display("FAIL lock_expected[%0d] got=%h model=%h want=%h", i, expected, m_expected, tbl[i]); bad++;
            end
            total++;
            if (match_pulse !== 1'b1 || mismatch_pulse !== 1'b0) begin
                $display("FAIL lock_match[%0d] got=%b%b want=10", i, match_pulse, mismatch_pulse); bad++;
            end
            total++;
            if (locked !== (i == 3)) begin
                $display("FAIL lock_locked[%0d] got=%b want=%b", i, locked, (i == 3)); bad++;
            end
            total++;
        end
        if (err_count !== 16'd0) begin $display("FAIL lock_err got=%0d want=0", err_count); bad++; end
        total++;
    endtask

    task automatic test_isolated_error();
        int ew = model_peek();
        send((ew == 0) ? 15 : 0);
        if (mismatch_pulse !== 1'b1 || match_pulse !== 1'b0 || locked !== 1'b1 || err_count !== 16'd1) begin
            $display("FAIL iso_err got=mm%b m%b lk%b err%0d want=mm1 m0 lk1 err1",
                     mismatch_pulse, match_pulse, locked, err_count); bad++;
        end
        total++;
        send(model_peek());
        if (match_pulse !== 1'b1 || locked !== 1'b1 || err_count !== 16'd1) begin
            $display("FAIL iso_resume got=m%b lk%b err%0d want=m1 lk1 err1", match_pulse, locked, err_count); bad++;
        end
        total++;
        idle(3);
        if (match_pulse !== 1'b0 || mismatch_pulse !== 1'b0 || expected !== 4'(m_expected)) begin
            $display("FAIL idle_hold got=m%b mm%b exp%h want=m0 mm0 exp%h",
                     match_pulse, mismatch_pulse, expected, m_expected); bad++;
        end
        total++;
    endtask

    task automatic test_random();
        do_restart();
        for (int n = 0; n < 300; n++) begin
            int ew = model_peek();
            int w = ($urandom_range(0, 9) == 0) ? (ew ^ int'($urandom_range(1, 15))) : ew;
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
            send(w);
            if (expected !== 4'(m_expected) || match_pulse !== m_match || mismatch_pulse !== m_mismatch ||
                locked !== m_locked || lost !== m_lost || err_count !== 16'(m_err)) begin
                $display("FAIL random[%0d] got=exp%h m%b mm%b lk%b ls%b err%0d want=exp%h m%b mm%b lk%b ls%b err%0d",
                         n, expected, match_pulse, mismatch_pulse, locked, lost, err_count,
                         m_expected, m_match, m_mismatch, m_locked, m_lost, m_err); bad++;
            end
            total++;
`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
            if (bit_err_count !== 16'(m_bit_err)) begin
                $display("FAIL random_bits[%0d] got=%0d want=%0d", n, bit_err_count, m_bit_err); bad++;
            end
            total++;
`endif
        end
    endtask

    task automatic test_loss();
        do_restart();
        for (int i = 0; i < 4; i++) send(model_peek());
        if (locked !== 1'b1) begin $display("FAIL loss_prelock got=%b want=1", locked); bad++; end
        total++;
        for (int i = 0; i < 3; i++) begin
            send(model_peek() ^ 5);
            if (mismatch_pulse !== 1'b1 || lost !== (i == 2) || locked !== (i != 2) || err_count !== 16'(i + 1)) begin
                $display("FAIL loss_step[%0d] got=mm%b ls%b lk%b err%0d want=mm1 ls%b lk%b err%0d",
                         i, mismatch_pulse, lost, locked, err_count, (i == 2), (i != 2), i + 1); bad++;
            end
            total++;
        end
        for (int i = 0; i < 2; i++) begin
            send(int'($urandom_range(0, 15)));
            if (match_pulse !== 1'b0 || mismatch_pulse !== 1'b0 || lost !== 1'b1 || err_count !== 16'd3 ||
                expected !== 4'(m_expected)) begin
                $display("FAIL lost_frozen[%0d] got=m%b mm%b ls%b err%0d exp%h want=m0 mm0 ls1 err3 exp%h",
                         i, match_pulse, mismatch_pulse, lost, err_count, expected, m_expected); bad++;
            end
            total++;
        end
    endtask

    task automatic test_restart_collision();
        @(negedge clk);
        restart = 1'b1; bus.data_valid = 1'b1; bus.data_in = 4'h1;
        @(posedge clk); #1;
        restart = 1'b0; bus.data_valid = 1'b0;
        model_reset();
        if (lost !== 1'b0 || err_count !== 16'd0 || match_pulse !== 1'b0 || mismatch_pulse !== 1'b0) begin
            $display("FAIL collide got=ls%b err%0d m%b mm%b want=ls0 err0 m0 mm0",
                     lost, err_count, match_pulse, mismatch_pulse); bad++;
        end
        total++;
        send(1);
        if (match_pulse !== 1'b1 || expected !== 4'h1) begin
            $display("FAIL collide_seed got=m%b exp%h want=m1 exp1", match_pulse, expected); bad++;
        end
        total++;
    endtask

    task automatic test_saturation();
        int unsigned s = 1;
        do_restart();
        for (int i = 0; i < 5; i++) begin
            int unsigned nxt;
            int ew = gen_word(s, nxt);
            s = nxt;
            @(negedge clk);
            bus_s.data_in = 4'(~ew); bus_s.data_valid = 1'b1;
            @(posedge clk); #1;
            bus_s.data_valid = 1'b0;
            if (s_mismatch !== 1'b1 || s_err !== 2'((i >= 2) ? 3 : i + 1) || s_lost !== 1'b0) begin
                $display("FAIL sat[%0d] got=mm%b err%0d ls%b want=mm1 err%0d ls0",
                         i, s_mismatch, s_err, s_lost, (i >= 2) ? 3 : i + 1); bad++;
            end
            total++;
        end
    endtask

`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
    task automatic test_bit_err();
        do_restart();
        send(1);
        send(8);
        if (bit_err_count !== 16'd4 || m_bit_err != 4) begin
            $display("FAIL bit_err_a got=%0d model=%0d want=4", bit_err_count, m_bit_err); bad++;
        end
        total++;
        send(5);
        if (bit_err_count !== 16'd5 || m_bit_err != 5) begin
            $display("FAIL bit_err_b got=%0d model=%0d want=5", bit_err_count, m_bit_err); bad++;
        end
        total++;
    endtask
`endif

    task automatic test_async_reset();
        do_restart();
        send(1);
        send(0);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        if ({expected, match_pulse, mismatch_pulse, locked, lost} !== 8'h00 || err_count !== 16'd0) begin
            $display("FAIL async_reset got=%h err%0d want=00 err0",
                     {expected, match_pulse, mismatch_pulse, locked, lost}, err_count); bad++;
        end
        total++;
        @(negedge clk); reset = 1'b0;
        model_reset();
        send(1);
        if (match_pulse !== 1'b1 || expected !== 4'h1) begin
            $display("FAIL async_restart got=m%b exp%h want=m1 exp1", match_pulse, expected); bad++;
        end
        total++;
    endtask

    initial begin
        bus.data_valid = 1'b0; bus.data_in = '0;
        bus_s.data_valid = 1'b0; bus_s.data_in = '0;
        test_reset();
        test_lock();
        test_isolated_error();
        test_loss();
        test_restart_collision();
        test_random();
        test_saturation();
`ifdef GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN
        test_bit_err();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/galois_lfsr_checker.md
Name: galois_lfsr_checker

Overview:
- Receive-side counterpart of galois_lfsr: consumes the pseudo-random nibbles popped from fifo_0 and checks them against a locally regenerated copy of the same sequence.
- Reports per-word match/mismatch, lock status, loss of lock and a saturating error count.
- Sits downstream of the FIFO read port in the XC7A35T top level; drives debug LEDs.

Parameters:
- LFSR_WIDTH, 8, reference LFSR state width; must equal the generator's.
- LFSR_SEED, 1, state loaded on reset/restart; must equal the generator's and be non-zero.
- LFSR_POLYNOMIAL, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1); must equal the generator's.
- LFSR_OUTPUT_BITS_PER_CLOCK, 4, bits checked per valid word.
- LOCK_COUNT, 4, consecutive matching words required to assert locked.
- LOSS_COUNT, 3, consecutive mismatching words that force the LOST state.
- ERR_CNT_WIDTH, 16, width of err_count.

Ports:
- clk  in  1  system clock (clk_out1 domain)
- reset  in  1  asynchronous, active-high reset
- restart  in  1  synchronous pulse: reload seed, clear counters, return to HUNT
- data_in  in  LFSR_OUTPUT_BITS_PER_CLOCK  received word (bit 0 = earliest generated bit)
- data_valid  in  1  data_in is valid this cycle (one word per asserted cycle)
- expected  out  LFSR_OUTPUT_BITS_PER_CLOCK  registered copy of the last expected word
- match_pulse  out  1  one-cycle pulse: last word matched
- mismatch_pulse  out  1  one-cycle pulse: last word mismatched
- locked  out  1  in LOCKED state
- lost  out  1  in LOST state (sticky until restart/reset)
- err_count  out  ERR_CNT_WIDTH  mismatched-word count, saturating

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; reference state = LFSR_SEED; FSM state = HUNT; run counters = 0.
- Galois step, shared convention with galois_lfsr:
  - Output bit = state[0].
  - Next state = (state >> 1) ^ (state[0] ? LFSR_POLYNOMIAL : 0).
  - One word = LFSR_OUTPUT_BITS_PER_CLOCK steps; bit k of the word is the k-th step's output.
  - Combinational unroll; the reference advances exactly one word per data_valid.
- Compare: the word is a match iff data_in equals the expected word. All outputs are registered, so response latency is 1 cycle after the data_valid cycle. expected updates with every data_valid.
- Without data_valid: pulses are 0 and state and counters hold.
- FSM:
  - HUNT (locked=0, lost=0):
    - Match increments good_run; at LOCK_COUNT, go to LOCKED.
    - Mismatch clears good_run and increments bad_run; at LOSS_COUNT, go to LOST.
  - LOCKED (locked=1):
    - Match clears bad_run.
    - Mismatch increments bad_run; at LOSS_COUNT, go to LOST.
    - An isolated mismatch does not drop lock.
  - LOST (locked=0, lost=1):
    - Reference LFSR frozen; data_valid ignored; no pulses; err_count frozen.
    - Exit only via restart or reset.
- err_count: +1 per mismatched word in HUNT and LOCKED; saturates at all-ones with no wrap.
- Simultaneous restart and data_valid: restart wins; the word is discarded, with no pulse and no count.
- Reset mid-operation: immediate return to reset values regardless of state.
- The run counters saturate at their thresholds; they are sized by $clog2 of the threshold plus 1.
- Elaboration check: LFSR_SEED must be non-zero and fit in LFSR_WIDTH; otherwise $error.

Optional Feature:
- Macro: GALOIS_LFSR_CHECKER_BIT_ERR_CNT_EN.
- Defined:
  - Adds output bit_err_count, ERR_CNT_WIDTH bits, reset 0.
  - Accumulates popcount(data_in ^ expected word) on every checked word.
  - Saturating; cleared by restart; frozen in LOST.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then drive data_valid with words 4'h1, 4'h7, 4'h4, 4'hA on consecutive cycles -> 4 match_pulses; expected follows 1,7,4,A; locked=1 one cycle after the 4th word; err_count=0.
- After lock, corrupt one word (send 4'h0 in place of the expected word), then resume the correct sequence -> one mismatch_pulse; err_count=1; locked stays 1; the next word matches.
- After lock, send 3 consecutive wrong words -> 3 mismatch_pulses; lost=1 and locked=0 after the 3rd; further data_valid produces no pulses; err_count=3.
- From LOST, pulse restart together with data_valid=1, data_in=4'h1 -> the word is ignored; lost=0, err_count=0. The next word 4'h1 matches, i.e. the reference was reloaded to the seed.
- Set ERR_CNT_WIDTH=2 and send 5 mismatching words from HUNT with LOSS_COUNT=8 -> err_count saturates at 3.
- Macro defined: expected word 4'h7, send 4'h8 -> bit_err_count=4. Then expected 4'h4, send 4'h5 -> bit_err_count=5.
- Assert reset asynchronously mid-stream, between clock edges -> all outputs are 0 immediately, and the sequence restarts at 4'h1.
